// File: rtl/rx_lane_write_arbiter_pkg.sv
// Shared constants, write-entry type and round-robin helper for the receive-lane write arbiter.
package rx_arb_pkg;

    localparam int RX_LANES      = 4;
    localparam int RX_ADDR_W     = 18;
    localparam int RX_DATA_W     = 5;
    localparam int RX_FIFO_DEPTH = 4;

    typedef struct packed {
        logic                 is_c;
        logic [RX_ADDR_W-2:0] addr;
        logic [RX_DATA_W-1:0] data;
    } rx_wr_entry_t;

    // Lane after the granted one, wrapping LANES-1 back to 0.
    function automatic int unsigned rr_next(input int unsigned granted, input int unsigned lanes);
        if (granted >= lanes - 32'd1) begin
            return 32'd0;
        end else begin
            return granted + 32'd1;
        end
    endfunction

endpackage

// File: rtl/rx_lane_write_arbiter_fifo.sv
// Per-lane synchronous write FIFO with flush; a push into a full FIFO is taken only alongside a pop.
module rx_lane_fifo #(
    parameter int WIDTH = 23,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             push_ok_s, pop_ok_s;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok_s  = pop & ~empty;
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (push_ok_s && !flush) begin
            mem_q[wr_ptr_q[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/rx_lane_write_arbiter.sv
// Round-robin arbiter sharing the Y/C frame-memory write port among receive lanes.
// Optional per-lane write counters are built when RX_ARB_STATS_EN is defined.
module rx_lane_write_arbiter
    import rx_arb_pkg::*;
#(
    parameter int LANES      = RX_LANES,
    parameter int ADDR_W     = RX_ADDR_W,
    parameter int DATA_W     = RX_DATA_W,
    parameter int FIFO_DEPTH = RX_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     enable,
    input  logic [LANES-1:0]         lane_wr_y,
    input  logic [LANES-1:0]         lane_wr_c,
    input  logic [LANES*ADDR_W-1:0]  lane_add,
    input  logic [LANES*DATA_W-1:0]  lane_data,
    input  logic                     rd_slot,
    input  logic                     ovf_clr,
    output logic                     mem_we,
    output logic                     mem_is_c,
    output logic [$clog2(LANES)-1:0] mem_lane,
    output logic [ADDR_W-2:0]        mem_add,
    output logic [DATA_W-1:0]        mem_data,
`ifdef RX_ARB_STATS_EN
    input  logic                     cnt_clr,
    output logic [LANES*16-1:0]      wr_count,
`endif
    output logic [LANES-1:0]         ovf
);
    localparam int LW = $clog2(LANES);

    typedef struct packed {
        logic              is_c;
        logic [ADDR_W-2:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;
    localparam int EW = $bits(entry_t);

    logic [LANES-1:0]  push_s, pop_s, empty_s, full_s, ovf_set_s, add_lsb_s;
    entry_t            din_s  [LANES];
    entry_t            dout_s [LANES];
    logic              grant_s;
    logic [LW-1:0]     gnt_idx_s, idx_s;
    entry_t            head_s;
    logic              unused_add_lsb_s;

    logic [LW-1:0]     rr_q, rr_d;
    logic              mem_we_q, mem_we_d, mem_is_c_q, mem_is_c_d;
    logic [LW-1:0]     mem_lane_q, mem_lane_d;
    logic [ADDR_W-2:0] mem_add_q, mem_add_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic [LANES-1:0]  ovf_q, ovf_d;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        // Y wins when both strobes fire; the lost C sample is flagged as an overflow.
        assign push_s[i]    = enable & (lane_wr_y[i] | lane_wr_c[i]);
        assign din_s[i]     = '{is_c: ~lane_wr_y[i],
                                addr: lane_add[i*ADDR_W+1 +: ADDR_W-1],
                                data: lane_data[i*DATA_W +: DATA_W]};
        assign pop_s[i]     = grant_s & (gnt_idx_s == LW'(i));
        assign ovf_set_s[i] = (enable & lane_wr_y[i] & lane_wr_c[i])
                            | (push_s[i] & full_s[i] & ~pop_s[i]);
        assign add_lsb_s[i] = lane_add[i*ADDR_W];

        rx_lane_fifo #(
            .WIDTH (EW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rstn  (rstn),
            .flush (~enable),
            .push  (push_s[i]),
            .pop   (pop_s[i]),
            .din   (din_s[i]),
            .dout  (dout_s[i]),
            .empty (empty_s[i]),
            .full  (full_s[i])
        );
    end

    // Byte-address LSB selects nothing: memory words are addressed by add[ADDR_W-1:1].
    assign unused_add_lsb_s = ^add_lsb_s;

    // Round-robin scan starting at rr; the read side owns memory while rd_slot is high.
    always_comb begin
        grant_s   = 1'b0;
        gnt_idx_s = '0;
        idx_s     = '0;
        if (enable && !rd_slot) begin
            for (int k = 0; k < LANES; k++) begin
                idx_s = LW'((32'(rr_q) + 32'(k)) % 32'(LANES));
                if (!grant_s && !empty_s[idx_s]) begin
                    grant_s   = 1'b1;
                    gnt_idx_s = idx_s;
                end else begin
                    gnt_idx_s = gnt_idx_s;
                end
            end
        end else begin
            grant_s = 1'b0;
        end
    end

    assign head_s = dout_s[gnt_idx_s];

    // Next state for rr, the output register and the sticky overflow flags.
    always_comb begin
        rr_d       = rr_q;
        mem_we_d   = grant_s;
        mem_is_c_d = mem_is_c_q;
        mem_lane_d = mem_lane_q;
        mem_add_d  = mem_add_q;
        mem_data_d = mem_data_q;
        if (grant_s) begin
            rr_d       = LW'(rr_next(32'(gnt_idx_s), 32'(LANES)));
            mem_is_c_d = head_s.is_c;
            mem_lane_d = gnt_idx_s;
            mem_add_d  = head_s.addr;
            mem_data_d = head_s.data;
        end else begin
            rr_d = rr_q;
        end
        ovf_d = (ovf_q & ~{LANES{ovf_clr}}) | ovf_set_s;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_q       <= '0;
            mem_we_q   <= 1'b0;
            mem_is_c_q <= 1'b0;
            mem_lane_q <= '0;
            mem_add_q  <= '0;
            mem_data_q <= '0;
            ovf_q      <= '0;
        end else begin
            rr_q       <= rr_d;
            mem_we_q   <= mem_we_d;
            mem_is_c_q <= mem_is_c_d;
            mem_lane_q <= mem_lane_d;
            mem_add_q  <= mem_add_d;
            mem_data_q <= mem_data_d;
            ovf_q      <= ovf_d;
        end
    end

    assign mem_we   = mem_we_q;
    assign mem_is_c = mem_is_c_q;
    assign mem_lane = mem_lane_q;
    assign mem_add  = mem_add_q;
    assign mem_data = mem_data_q;
    assign ovf      = ovf_q;

`ifdef RX_ARB_STATS_EN
    logic [15:0] cnt_q [LANES];

    // Saturating per-lane write counters, stepped with the output register so they track emitted writes.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int k = 0; k < LANES; k++) begin
                cnt_q[k] <= 16'd0;
            end
        end else if (cnt_clr) begin
            for (int k = 0; k < LANES; k++) begin
                cnt_q[k] <= 16'd0;
            end
        end else if (grant_s && (cnt_q[gnt_idx_s] != 16'hFFFF)) begin
            cnt_q[gnt_idx_s] <= cnt_q[gnt_idx_s] + 16'd1;
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_cnt
        assign wr_count[i*16 +: 16] = cnt_q[i];
    end
`endif

endmodule

// File: tb/tb_rx_lane_write_arbiter.sv
// Self-checking bench: directed vector table, multi-cycle corner sequences and random traffic vs a queue model.
module tb_rx_lane_write_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic [3:0]  lane_wr_y = 4'h0;
    logic [3:0]  lane_wr_c = 4'h0;
    logic [71:0] lane_add = 72'h0;
    logic [19:0] lane_data = 20'h0;
    logic        rd_slot = 1'b0;
    logic        ovf_clr = 1'b0;
    logic        cnt_clr = 1'b0;
    logic        mem_we, mem_is_c;
    logic [1:0]  mem_lane;
    logic [16:0] mem_add;
    logic [4:0]  mem_data;
    logic [3:0]  ovf;
`ifdef RX_ARB_STATS_EN
    logic [63:0] wr_count;
`endif

    int total = 0;
    int bad   = 0;

    rx_lane_write_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .enable    (enable),
        .lane_wr_y (lane_wr_y),
        .lane_wr_c (lane_wr_c),
        .lane_add  (lane_add),
        .lane_data (lane_data),
        .rd_slot   (rd_slot),
        .ovf_clr   (ovf_clr),
        .mem_we    (mem_we),
        .mem_is_c  (mem_is_c),
        .mem_lane  (mem_lane),
        .mem_add   (mem_add),
        .mem_data  (mem_data),
`ifdef RX_ARB_STATS_EN
        .cnt_clr   (cnt_clr),
        .wr_count  (wr_count),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: one queue per lane, a round-robin index, expected registered outputs.
    typedef struct packed {
        logic        is_c;
        logic [16:0] addr;
        logic [4:0]  data;
    } ent_t;

    ent_t        q [4][$];
    int          rr;
    logic        e_we, e_is_c;
    logic [1:0]  e_lane;
    logic [16:0] e_add;
    logic [4:0]  e_data;
    logic [3:0]  e_ovf;
    int          e_cnt [4];

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            q[i].delete();
            e_cnt[i] = 0;
        end
        rr = 0; e_we = 1'b0; e_is_c = 1'b0; e_lane = 2'd0;
        e_add = 17'h0; e_data = 5'h0; e_ovf = 4'h0;
    endtask

    task automatic model_step();
        int   g;
        int   idx;
        logic [3:0] set;
        ent_t ent;
        g = -1;
        set = 4'h0;
        if (enable && !rd_slot) begin
            for (int k = 0; k < 4; k++) begin
                idx = (rr + k) % 4;
                if (g < 0 && q[idx].size() > 0) g = idx;
            end
        end
        e_we = (g >= 0);
        if (g >= 0) begin
            ent = q[g].pop_front();
            e_is_c = ent.is_c; e_lane = 2'(g); e_add = ent.addr; e_data = ent.data;
            rr = (g + 1) % 4;
            if (!cnt_clr && e_cnt[g] < 65535) e_cnt[g] = e_cnt[g] + 1;
        end
        if (cnt_clr) begin
            for (int i = 0; i < 4; i++) e_cnt[i] = 0;
        end
        if (!enable) begin
            for (int i = 0; i < 4; i++) q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (lane_wr_y[i] || lane_wr_c[i]) begin
                    ent.is_c = !lane_wr_y[i];
                    ent.addr = lane_add[i*18+1 +: 17];
                    ent.data = lane_data[i*5 +: 5];
                    if (lane_wr_y[i] && lane_wr_c[i]) set[i] = 1'b1;
                    if (q[i].size() < 4) q[i].push_back(ent);
                    else set[i] = 1'b1;
                end
            end
        end
        e_ovf = (e_ovf & ~{4{ovf_clr}}) | set;
    endtask

    task automatic check_model();
        total++;
        if ({mem_we, mem_is_c, mem_lane, mem_add, mem_data} !== {e_we, e_is_c, e_lane, e_add, e_data}) begin
            bad++;
            $display("FAIL bus @%0t: got we=%b c=%b lane=%0d add=%h data=%h, want we=%b c=%b lane=%0d add=%h data=%h",
                     $time, mem_we, mem_is_c, mem_lane, mem_add, mem_data, e_we, e_is_c, e_lane, e_add, e_data);
        end
        total++;
        if (ovf !== e_ovf) begin
            bad++;
            $display("FAIL ovf @%0t: got %b want %b", $time, ovf, e_ovf);
        end
`ifdef RX_ARB_STATS_EN
        for (int i = 0; i < 4; i++) begin
            total++;
            if (wr_count[i*16 +: 16] !== 16'(e_cnt[i])) begin
                bad++;
                $display("FAIL wr_count[%0d] @%0t: got %0d want %0d", i, $time, wr_count[i*16 +: 16], e_cnt[i]);
            end
        end
`endif
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic expect_val(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic set_lane(input int i, input logic [17:0] add, input logic [4:0] data);
        lane_add[i*18 +: 18] = add;
        lane_data[i*5 +: 5]  = data;
    endtask

    typedef struct {
        logic [3:0]  y;
        logic [3:0]  c;
        logic        clr;
        logic [17:0] abase;
        logic [4:0]  dbase;
        logic        we;
        logic        is_c;
        logic [1:0]  lane;
        logic [16:0] add;
        logic [4:0]  data;
        logic [3:0]  ov;
    } vec_t;

    vec_t tv [15];
    int   wcnt;
    logic [4:0] obs [$];

    initial begin
        // Lane i drives add = abase + 32*i, data = dbase + i; rd_slot=0, enable=1.
        tv[0]  = '{4'hF, 4'h0, 1'b0, 18'h100, 5'h01, 1'b0, 1'b0, 2'd0, 17'h000, 5'h00, 4'h0};
        tv[1]  = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b0, 2'd0, 17'h080, 5'h01, 4'h0};
        tv[2]  = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b0, 2'd1, 17'h090, 5'h02, 4'h0};
        tv[3]  = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b0, 2'd2, 17'h0A0, 5'h03, 4'h0};
        tv[4]  = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b0, 2'd3, 17'h0B0, 5'h04, 4'h0};
        tv[5]  = '{4'h1, 4'h0, 1'b0, 18'h010, 5'h0A, 1'b0, 1'b0, 2'd3, 17'h0B0, 5'h04, 4'h0};
        tv[6]  = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b0, 2'd0, 17'h008, 5'h0A, 4'h0};
        tv[7]  = '{4'h2, 4'h2, 1'b0, 18'h200, 5'h11, 1'b0, 1'b0, 2'd0, 17'h008, 5'h0A, 4'h2};
        tv[8]  = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b0, 2'd1, 17'h110, 5'h12, 4'h2};
        tv[9]  = '{4'h0, 4'h0, 1'b1, 18'h000, 5'h00, 1'b0, 1'b0, 2'd1, 17'h110, 5'h12, 4'h0};
        tv[10] = '{4'h0, 4'h4, 1'b0, 18'h000, 5'h03, 1'b0, 1'b0, 2'd1, 17'h110, 5'h12, 4'h0};
        tv[11] = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b1, 2'd2, 17'h020, 5'h05, 4'h0};
        tv[12] = '{4'h8, 4'h8, 1'b1, 18'h000, 5'h00, 1'b0, 1'b1, 2'd2, 17'h020, 5'h05, 4'h8};
        tv[13] = '{4'h0, 4'h0, 1'b0, 18'h000, 5'h00, 1'b1, 1'b0, 2'd3, 17'h030, 5'h03, 4'h8};
        tv[14] = '{4'h0, 4'h0, 1'b1, 18'h000, 5'h00, 1'b0, 1'b0, 2'd3, 17'h030, 5'h03, 4'h0};

        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        enable = 1'b1;
        #1;
        expect_val("reset_outputs", int'({mem_we, mem_is_c, mem_lane, mem_add, mem_data, ovf}), 0);
        check_model();

        // Directed vector table.
        for (int r = 0; r < 15; r++) begin
            lane_wr_y = tv[r].y;
            lane_wr_c = tv[r].c;
            ovf_clr   = tv[r].clr;
            for (int i = 0; i < 4; i++) set_lane(i, tv[r].abase + 18'(i*32), tv[r].dbase + 5'(i));
            step();
            total++;
            if ({mem_we, mem_is_c, mem_lane, mem_add, mem_data, ovf} !==
                {tv[r].we, tv[r].is_c, tv[r].lane, tv[r].add, tv[r].data, tv[r].ov}) begin
                bad++;
                $display("FAIL vec[%0d]: got we=%b c=%b lane=%0d add=%h data=%h ovf=%b, want we=%b c=%b lane=%0d add=%h data=%h ovf=%b",
                         r, mem_we, mem_is_c, mem_lane, mem_add, mem_data, ovf,
                         tv[r].we, tv[r].is_c, tv[r].lane, tv[r].add, tv[r].data, tv[r].ov);
            end
        end
        lane_wr_y = 4'h0; lane_wr_c = 4'h0; ovf_clr = 1'b0;

        // Lane 2 overflow: five pushes while the read side holds memory.
        rd_slot = 1'b1;
        for (int k = 0; k < 5; k++) begin
            lane_wr_y = 4'h4;
            set_lane(2, 18'(k*2 + 2), 5'(k + 1));
            step();
        end
        lane_wr_y = 4'h0;
        step();
        expect_val("ovf2_set", int'(ovf[2]), 1);
        rd_slot = 1'b0;
        obs.delete();
        for (int k = 0; k < 6; k++) begin
            step();
            if (mem_we && mem_lane == 2'd2) obs.push_back(mem_data);
        end
        expect_val("ovf2_writes", obs.size(), 4);
        for (int k = 0; k < obs.size() && k < 4; k++) expect_val("ovf2_order", int'(obs[k]), k + 1);
        expect_val("ovf2_sticky", int'(ovf[2]), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        expect_val("ovf2_clr", int'(ovf), 0);

        // rd_slot toggling with two entries queued on lane 3.
        rd_slot = 1'b1;
        for (int k = 0; k < 2; k++) begin
            lane_wr_y = 4'h8;
            set_lane(3, 18'(16'h400 + k*2), 5'(k + 7));
            step();
        end
        lane_wr_y = 4'h0;
        for (int k = 0; k < 4; k++) begin
            rd_slot = (k % 2 == 0);
            step();
            expect_val("rdslot_we", int'(mem_we), (k % 2));
        end

        // enable dropped with entries queued: the write already granted completes, the rest is flushed.
        rd_slot = 1'b1;
        lane_wr_y = 4'h3; set_lane(0, 18'h500, 5'h15); set_lane(1, 18'h502, 5'h16);
        step();
        lane_wr_y = 4'h1; set_lane(0, 18'h504, 5'h17);
        step();
        lane_wr_y = 4'h0;
        rd_slot = 1'b0;
        step();
        expect_val("en_prior_we", int'(mem_we), 1);
        enable = 1'b0;
        step();
        expect_val("en_low_we", int'(mem_we), 0);
        enable = 1'b1;
        wcnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            wcnt += int'(mem_we);
        end
        expect_val("en_flush", wcnt, 0);

        // Asynchronous reset with entries queued.
        rd_slot = 1'b1;
        lane_wr_y = 4'hF;
        step();
        step();
        lane_wr_y = 4'h0;
        rstn = 1'b0;
        #2;
        expect_val("midrst_outputs", int'({mem_we, mem_is_c, mem_lane, mem_add, mem_data, ovf}), 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        rd_slot = 1'b0;
        wcnt = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            wcnt += int'(mem_we);
        end
        expect_val("midrst_nowrite", wcnt, 0);

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            lane_wr_y = 4'($urandom) & 4'($urandom);
            lane_wr_c = 4'($urandom) & 4'($urandom) & 4'($urandom);
            lane_add  = 72'({$urandom, $urandom, $urandom});
            lane_data = 20'($urandom);
            rd_slot   = ($urandom_range(0, 3) == 0);
            enable    = ($urandom_range(0, 29) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            cnt_clr   = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
